// File: rtl/mra_pkg.sv
// Shared types and helpers for the mra_rr multi-resource round-robin arbiter.
// Search helpers work on a fixed maximum width so they can serve any N and M up to MAX_W.
package mra_pkg;

  localparam int IW    = 6;
  localparam int MAX_W = 1 << IW;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
  } pick_t;

  // Resource index width; a single resource still needs one bit.
  function automatic int rw_of(input int m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  // First set bit of mask scanning ptr, ptr+1, ... wrapping at n-1 -> 0.
  function automatic pick_t rr_first(input logic [MAX_W-1:0] mask, input int ptr, input int n);
    pick_t r;
    int    i;
    r = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if (k < n && !r.valid) begin
        i = ptr + k;
        if (i >= n) i = i - n;
        if (mask[IW'(i)]) begin
          r.valid = 1'b1;
          r.idx   = IW'(i);
        end
      end
    end
    return r;
  endfunction

  // Lowest-index set bit among the first m bits of mask.
  function automatic pick_t lowest_free(input logic [MAX_W-1:0] mask, input int m);
    pick_t r;
    r = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if (k < m && !r.valid && mask[IW'(k)]) begin
        r.valid = 1'b1;
        r.idx   = IW'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational N-wide round-robin priority picker: mask + start pointer -> onehot, index, valid.
module rr_pick
  import mra_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          valid
);

  pick_t r;
  logic  unused_idx;

  assign r          = rr_first(MAX_W'(mask), int'(ptr), N);
  assign valid      = r.valid;
  assign idx        = PW'(r.idx);
  assign onehot     = r.valid ? (N'(1) << idx) : '0;
  assign unused_idx = ^r.idx;

endmodule

// File: rtl/mra_rr.sv
// N-requester / M-resource round-robin arbiter with four-phase req/gnt handshake.
// Define MRA_MULTI_GRANT_EN to allow up to min(pending, free) grants per edge.
module mra_rr
  import mra_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int M  = 2,
  localparam int RW = rw_of(M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [N*RW-1:0] gnt_res,
  output logic [M-1:0]    res_busy,
  output logic            all_busy
);

  localparam int PW = $clog2(N);
`ifdef MRA_MULTI_GRANT_EN
  localparam int G = (M < N) ? M : N;
`else
  localparam int G = 1;
`endif
  localparam int L = G - 1;

  logic [PW-1:0]   ptr;
  logic [N-1:0]    pending;
  logic [M-1:0]    free;
  logic [M-1:0]    rel;
  logic [N-1:0]    new_gnt;
  logic [M-1:0]    new_busy;
  logic [N*RW-1:0] gres_next;
  logic [PW-1:0]   ptr_next;

  // Allocation only sees resources free before this edge, so a release is never reused on its own edge.
  assign pending = req & ~gnt;
  assign free    = ~res_busy;

  // Each stage grants at most one requester; stages chain the remaining candidates and free set.
  for (genvar k = 0; k < G; k++) begin : g_stage
    logic [N-1:0]    cand_in,  cand_out;
    logic [PW-1:0]   start_in, start_out;
    logic [M-1:0]    fmask_in, fmask_out;
    logic [N*RW-1:0] gres_in,  gres_out;
    logic [N-1:0]    win_oh;
    logic [PW-1:0]   win_idx;
    logic            win_valid;
    pick_t           res;
    logic [RW-1:0]   res_idx;
    logic            hit;
    logic            unused_res;

    if (k == 0) begin : g_head
      assign cand_in  = pending;
      assign start_in = ptr;
      assign fmask_in = free;
      assign gres_in  = gnt_res;
    end else begin : g_link
      assign cand_in  = g_stage[k-1].cand_out;
      assign start_in = g_stage[k-1].start_out;
      assign fmask_in = g_stage[k-1].fmask_out;
      assign gres_in  = g_stage[k-1].gres_out;
    end

    rr_pick #(.N(N)) u_pick (
      .mask   (cand_in),
      .ptr    (start_in),
      .onehot (win_oh),
      .idx    (win_idx),
      .valid  (win_valid)
    );

    assign res        = lowest_free(MAX_W'(fmask_in), M);
    assign res_idx    = RW'(res.idx);
    assign unused_res = ^res.idx;
    assign hit        = win_valid & res.valid;

    assign cand_out  = hit ? (cand_in & ~win_oh) : cand_in;
    assign fmask_out = hit ? (fmask_in & ~(M'(1) << res_idx)) : fmask_in;
    assign start_out = !hit                    ? start_in :
                       (win_idx == PW'(N - 1)) ? '0       : win_idx + 1'b1;

    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
      gres_out = gres_in;
      if (hit) gres_out[win_idx*RW +: RW] = res_idx;
    end
  end

  assign new_gnt   = pending & ~g_stage[L].cand_out;
  assign new_busy  = free & ~g_stage[L].fmask_out;
  assign gres_next = g_stage[L].gres_out;
  assign ptr_next  = g_stage[L].start_out;

  always_comb begin
    rel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i] && !req[i]) begin
        for (int j = 0; j < M; j++) begin
          if (gnt_res[i*RW +: RW] == RW'(j)) rel[j] = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      gnt_res  <= '0;
      res_busy <= '0;
      ptr      <= '0;
    end else begin
      gnt      <= (gnt & req) | new_gnt;
      gnt_res  <= gres_next;
      res_busy <= (res_busy & ~rel) | new_busy;
      ptr      <= ptr_next;
    end
  end

  assign all_busy = &res_busy;

endmodule

// File: doc/mra_rr.md
Name: mra_rr

Overview:
- Clocked, parametrised N-requester / M-resource arbiter with round-robin fairness and a four-phase req/gnt handshake per requester.
- Each grant carries the index of the resource allocated to that requester.
- Used at router output-port allocation, where M identical virtual/SDM sub-channels are shared among N input ports.

Parameters:
N, 4, number of requesters (≥2)
M, 2, number of identical resources (≥1)
RW, $clog2(M) (min 1), local: resource index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
req  in  N  per-requester request, four-phase level
gnt  out  N  per-requester grant
gnt_res  out  N*RW  resource index held by requester i, bits [i*RW +: RW]
res_busy  out  M  resource currently allocated
all_busy  out  1  &res_busy

Behaviour:
- Reset: while rst is sampled high, gnt=0, gnt_res=0, res_busy=0, all_busy=0, rr pointer ptr=0. Reset mid-handshake drops all grants on that edge; requesters see gnt low the next cycle.
- Per-requester state, derived from gnt[i]:
  - IDLE (gnt=0): req=1 makes the requester pending.
  - HELD (gnt=1): stays HELD while req=1.
  - HELD with req=0: on that edge gnt[i]<=0 and res_busy[gnt_res[i]]<=0. gnt_res[i] holds its last value; it is don't-care when gnt low.
- Handshake: requester raises req, waits for gnt=1, uses the resource, drops req, then waits for gnt=0 before re-raising.
- Grant latency: req high sampled at edge k with a resource free and the requester winning → gnt high after edge k (1 cycle). Release latency: req low sampled at edge k → gnt low after edge k.
- Allocation at each edge:
  - pending = req & ~gnt; free = ~res_busy, using pre-edge values.
  - If pending≠0 and free≠0: winner = first set bit of pending searching ptr, ptr+1, … wrapping mod N.
  - Resource = lowest-index free bit.
  - Set gnt[winner], gnt_res[winner], res_busy[resource]; ptr<=(winner+1) mod N.
  - Otherwise ptr is unchanged.
- At most one new grant per edge (unless the optional feature is enabled).
- Simultaneous release and request on the same edge: a freed resource is not reallocated on that edge. It is first grantable on the following edge.
- Full (all_busy=1): pending requesters wait indefinitely. Fairness: a continuously pending requester is granted within N allocation events.
- Protocol violation (req re-raised while gnt still high from a just-dropped req) is impossible by construction, because the release is registered. req glitches are not filtered.
- N not a power of two: pointer wraps at N-1→0 explicitly.

Optional Feature:
Macro MRA_MULTI_GRANT_EN.
- Defined: per edge, up to min(popcount(pending), popcount(free)) grants.
  - The k-th winner in round-robin order from ptr gets the k-th lowest free resource.
  - ptr<=(last winner+1) mod N.
- Undefined: single grant per edge as above.
- Latency, release and reset rules are identical in both builds.

Decomposition:
- Shared package mra_pkg:
  - function rr_first(mask, ptr) returning index and valid.
  - function lowest_free(mask).
  - RW computation helper.
- One natural sub-module: rr_pick, an N-wide round-robin priority picker (combinational, mask+ptr → onehot+index+valid). Instantiated once, or iteratively with masking under MRA_MULTI_GRANT_EN.
- The top level holds the registers and release logic.

Test Plan:
- N=4,M=2; reset, then req=0001 at edge 1 → gnt=0001, gnt_res[0]=0, res_busy=01 after edge 1; drop req → gnt=0000, res_busy=00 next edge.
- req=1111 held, ptr=0, single-grant build → grants in order 0,1 on successive edges, res 0 and 1, all_busy=1; 2 and 3 wait.
- From the full state, drop req[0] → edge k: gnt[0]=0. Edge k+1: requester 2 granted res 0, ptr=3 (not requester 0 even if re-raised).
- Fairness: req=1111 continuously, each holder drops req one cycle after grant → grant sequence 0,1,2,3,0,… with no requester skipped.
- Assert rst while two grants are held → all outputs 0 after that edge; with req held high, first grant goes to requester 0 one edge after rst deasserts.
- MRA_MULTI_GRANT_EN, M=2, req=0110, ptr=2 → one edge: gnt=0110, gnt_res[2]=0, gnt_res[1]=1, ptr=2.
